// File: rtl/input_debounce_if.sv
// Pad-side bundle of the debouncer: raw pad levels in, clean levels and edge pulses out.
// Bit mapping on every vector: bit0 encoder A, bit1 encoder B, bit2 pushbutton.
interface input_debounce_if;
  logic [2:0] raw_in;
  logic [2:0] clean_out;
  logic [2:0] rise_pulse;
  logic [2:0] fall_pulse;

  modport master (
    output raw_in,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/input_debounce.sv
// Three independent channels: two-flop synchronizer, then a stability counter that
// accepts a new level only after it has held for STABLE_CYCLES consecutive clocks.
module input_debounce #(
  parameter int         STABLE_CYCLES = 1000,
  parameter int         CNT_W         = 16,
  parameter logic [2:0] RST_LEVEL     = 3'b000
) (
  input  logic        clk,
  input  logic        rstn,
  input_debounce_if.slave dbif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       clean_q, clean_d;
  logic [2:0]       rise_q,  rise_d;
  logic [2:0]       fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  always_comb begin
    sync1_d = dbif.raw_in;
    sync2_d = sync1_q;
    clean_d = clean_q;
    rise_d  = 3'b000;
    fall_d  = 3'b000;
    for (int ch = 0; ch < 3; ch++) begin
      cnt_d[ch] = '0;
      if (sync2_q[ch] != clean_q[ch]) begin
        // Terminal count: accept the new level and emit its edge pulse on the same edge.
        if (cnt_q[ch] == CNT_LAST) begin
          clean_d[ch] = sync2_q[ch];
          rise_d[ch]  = sync2_q[ch];
          fall_d[ch]  = ~sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
      clean_q <= RST_LEVEL;
      rise_q  <= 3'b000;
      fall_q  <= 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign dbif.clean_out  = clean_q;
  assign dbif.rise_pulse = rise_q;
  assign dbif.fall_pulse = fall_q;

  for (genvar g = 0; g < 3; g++) begin : g_chk
    a_cnt_bound: assert property (@(posedge clk) cnt_q[g] <= CNT_LAST);
    a_one_edge:  assert property (@(posedge clk) !(rise_q[g] && fall_q[g]));
  end

endmodule
